// File: rtl/counter_timer_arbiter_if.sv
// Bus between the shared delay timer and its two requesters.
// The requester side drives req/len; the timer side drives gnt/done/count/busy.
interface counter_timer_arbiter_if #(
  parameter int WIDTH = 4
) ();
  logic [1:0]       req;
  logic [WIDTH-1:0] len0;
  logic [WIDTH-1:0] len1;
  logic [1:0]       gnt;
  logic [1:0]       done;
  logic [WIDTH-1:0] count;
  logic             busy;

  modport master (
    output req, len0, len1,
    input  gnt, done, count, busy
  );

  modport slave (
    input  req, len0, len1,
    output gnt, done, count, busy
  );
endinterface

// File: rtl/counter_timer_arbiter.sv
// Shared delay timer with a two-way round-robin arbiter.
// The owner's counter is cleared on grant, counts up to the length that was
// captured at grant time, and then the owner sees a one-cycle done pulse.
// Dropping req while owning the counter aborts the run without a done pulse.
module counter_timer_arbiter #(
  parameter int WIDTH = 4
) (
  input logic                   clk,
  input logic                   rstn,
  counter_timer_arbiter_if.slave bus
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state_q;
  logic [1:0]       gnt_q;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] target_q;
  logic             last_q;
  logic             busy_q;

  logic             other_s;
  logic             win_s;
  logic [WIDTH-1:0] len_win_s;
  logic             own_req_s;
  logic             hit_s;

  // Arbitration and expiry decode from the registered state and live requests.
  always_comb begin
    other_s   = ~last_q;
    win_s     = last_q;
    len_win_s = bus.len0;
    if (bus.req[other_s]) begin
      win_s = other_s;
    end else begin
      win_s = last_q;
    end
    if (win_s) begin
      len_win_s = bus.len1;
    end else begin
      len_win_s = bus.len0;
    end
    // While running, last_q always names the current owner.
    own_req_s = bus.req[last_q];
    hit_s     = (count_q == target_q);
  end

  // Timer FSM: grant, count to target, release or abort, with a forced idle cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= ST_IDLE;
      gnt_q    <= 2'b00;
      count_q  <= CNT_ZERO;
      target_q <= CNT_ZERO;
      last_q   <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          count_q <= CNT_ZERO;
          if (|bus.req) begin
            gnt_q    <= win_s ? 2'b10 : 2'b01;
            last_q   <= win_s;
            target_q <= len_win_s;
            busy_q   <= 1'b1;
            state_q  <= ST_RUN;
          end else begin
            gnt_q  <= 2'b00;
            busy_q <= 1'b0;
          end
        end
        ST_RUN: begin
          if (!own_req_s || hit_s) begin
            // Abort or expiry: both release the counter through one idle cycle.
            gnt_q   <= 2'b00;
            count_q <= CNT_ZERO;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            count_q <= count_q + CNT_ONE;
          end
        end
        default: begin
          gnt_q   <= 2'b00;
          count_q <= CNT_ZERO;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // done depends on the owner's live req so an abort in the expiry cycle
  // suppresses the pulse; gnt_q is one-hot or zero, so only the owner's bit can rise.
  assign bus.done  = gnt_q & bus.req & {2{hit_s}};
  assign bus.gnt   = gnt_q;
  assign bus.count = count_q;
  assign bus.busy  = busy_q;

endmodule

// File: tb/tb_counter_timer_arbiter.sv
// Self-checking bench for counter_timer_arbiter: a directed vector table,
// hand-written abort / reset sequences, and a randomized run against a
// timeline-style reference model.
module tb_counter_timer_arbiter;

  logic clk;
  logic rstn;

  counter_timer_arbiter_if #(.WIDTH(4)) bus ();

  counter_timer_arbiter #(.WIDTH(4)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_pass;

  // Reference model: who owns the timer, how many cycles since the grant,
  // the captured length, and who was granted last.
  int m_own;
  int m_k;
  int m_tgt;
  int m_last;

  typedef struct {
    logic [1:0] req;
    logic [3:0] l0;
    logic [3:0] l1;
    logic [1:0] gnt;
    logic [1:0] done;
    logic [3:0] cnt;
  } vec_t;

  vec_t tbl[31];

  task automatic chk(input string nm, input int got, input int exp);
    n_chk++;
    if (got == exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s t=%0t got %0d expected %0d", nm, $time, got, exp);
    end
  endtask

  function automatic int exp_gnt();
    if (m_own < 0) return 0;
    return (m_own == 1) ? 2 : 1;
  endfunction

  function automatic int exp_cnt();
    if (m_own < 0) return 0;
    return m_k;
  endfunction

  function automatic int exp_done();
    if (m_own >= 0 && m_k == m_tgt && bus.req[m_own] == 1'b1) return exp_gnt();
    return 0;
  endfunction

  task automatic model_check(input string tag);
    chk({tag, "_gnt"},   int'(bus.gnt),   exp_gnt());
    chk({tag, "_done"},  int'(bus.done),  exp_done());
    chk({tag, "_count"}, int'(bus.count), exp_cnt());
    chk({tag, "_busy"},  int'(bus.busy),  (m_own >= 0) ? 1 : 0);
  endtask

  // Apply the rules for one rising edge using the inputs present at that edge.
  task automatic model_edge();
    int w;
    if (m_own < 0) begin
      if (bus.req != 2'b00) begin
        w = (bus.req[1 - m_last] == 1'b1) ? (1 - m_last) : m_last;
        m_own  = w;
        m_last = w;
        m_k    = 0;
        m_tgt  = (w == 1) ? int'(bus.len1) : int'(bus.len0);
      end
    end else if (bus.req[m_own] == 1'b0 || m_k == m_tgt) begin
      m_own = -1;
      m_k   = 0;
    end else begin
      m_k = m_k + 1;
    end
  endtask

  task automatic drive_sample(input logic [1:0] r, input logic [3:0] l0,
                              input logic [3:0] l1, input bit use_model,
                              input string tag);
    bus.req  = r;
    bus.len0 = l0;
    bus.len1 = l1;
    @(negedge clk);
    if (use_model) model_check(tag);
  endtask

  task automatic advance();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic [1:0] r, input logic [3:0] l0,
                      input logic [3:0] l1, input string tag);
    drive_sample(r, l0, l1, 1'b1, tag);
    advance();
  endtask

  initial begin
    logic [1:0] rq;
    int guard;
    n_chk  = 0;
    n_pass = 0;
    m_own  = -1;
    m_k    = 0;
    m_tgt  = 0;
    m_last = 1;

    // req, len0, len1, gnt, done, count for each cycle after reset release
    tbl[0]  = '{2'b11, 4'd1, 4'd0, 2'b00, 2'b00, 4'd0};
    tbl[1]  = '{2'b11, 4'd1, 4'd0, 2'b01, 2'b00, 4'd0};
    tbl[2]  = '{2'b11, 4'd1, 4'd0, 2'b01, 2'b01, 4'd1};
    tbl[3]  = '{2'b10, 4'd1, 4'd0, 2'b00, 2'b00, 4'd0};
    tbl[4]  = '{2'b10, 4'd1, 4'd0, 2'b10, 2'b10, 4'd0};
    tbl[5]  = '{2'b11, 4'd2, 4'd3, 2'b00, 2'b00, 4'd0};
    tbl[6]  = '{2'b11, 4'd2, 4'd3, 2'b01, 2'b00, 4'd0};
    tbl[7]  = '{2'b11, 4'd2, 4'd3, 2'b01, 2'b00, 4'd1};
    tbl[8]  = '{2'b11, 4'd2, 4'd3, 2'b01, 2'b01, 4'd2};
    tbl[9]  = '{2'b11, 4'd2, 4'd3, 2'b00, 2'b00, 4'd0};
    tbl[10] = '{2'b11, 4'd2, 4'd3, 2'b10, 2'b00, 4'd0};
    tbl[11] = '{2'b11, 4'd2, 4'd3, 2'b10, 2'b00, 4'd1};
    tbl[12] = '{2'b11, 4'd2, 4'd3, 2'b10, 2'b00, 4'd2};
    tbl[13] = '{2'b11, 4'd2, 4'd3, 2'b10, 2'b10, 4'd3};
    tbl[14] = '{2'b11, 4'd2, 4'd3, 2'b00, 2'b00, 4'd0};
    tbl[15] = '{2'b11, 4'd2, 4'd3, 2'b01, 2'b00, 4'd0};
    tbl[16] = '{2'b11, 4'd2, 4'd3, 2'b01, 2'b00, 4'd1};
    tbl[17] = '{2'b11, 4'd2, 4'd3, 2'b01, 2'b01, 4'd2};
    tbl[18] = '{2'b11, 4'd2, 4'd3, 2'b00, 2'b00, 4'd0};
    tbl[19] = '{2'b11, 4'd2, 4'd3, 2'b10, 2'b00, 4'd0};
    tbl[20] = '{2'b11, 4'd2, 4'd3, 2'b10, 2'b00, 4'd1};
    tbl[21] = '{2'b11, 4'd2, 4'd3, 2'b10, 2'b00, 4'd2};
    tbl[22] = '{2'b11, 4'd2, 4'd3, 2'b10, 2'b10, 4'd3};
    tbl[23] = '{2'b01, 4'd5, 4'd3, 2'b00, 2'b00, 4'd0};
    tbl[24] = '{2'b01, 4'd5, 4'd3, 2'b01, 2'b00, 4'd0};
    tbl[25] = '{2'b01, 4'd5, 4'd3, 2'b01, 2'b00, 4'd1};
    tbl[26] = '{2'b01, 4'd5, 4'd3, 2'b01, 2'b00, 4'd2};
    tbl[27] = '{2'b01, 4'd5, 4'd3, 2'b01, 2'b00, 4'd3};
    tbl[28] = '{2'b01, 4'd5, 4'd3, 2'b01, 2'b00, 4'd4};
    tbl[29] = '{2'b01, 4'd5, 4'd3, 2'b01, 2'b01, 4'd5};
    tbl[30] = '{2'b00, 4'd5, 4'd3, 2'b00, 2'b00, 4'd0};

    // Reset held with both requesting: everything stays cleared.
    rstn     = 1'b0;
    bus.req  = 2'b11;
    bus.len0 = 4'd1;
    bus.len1 = 4'd0;
    #100;
    chk("reset_gnt",   int'(bus.gnt),   0);
    chk("reset_done",  int'(bus.done),  0);
    chk("reset_count", int'(bus.count), 0);
    chk("reset_busy",  int'(bus.busy),  0);
    @(posedge clk);
    #1;
    rstn = 1'b1;

    // Directed table: reset release, zero length, contention, single request.
    for (int i = 0; i < 31; i++) begin
      drive_sample(tbl[i].req, tbl[i].l0, tbl[i].l1, 1'b0, "tbl");
      chk($sformatf("tbl%0d_gnt", i),   int'(bus.gnt),   int'(tbl[i].gnt));
      chk($sformatf("tbl%0d_done", i),  int'(bus.done),  int'(tbl[i].done));
      chk($sformatf("tbl%0d_count", i), int'(bus.count), int'(tbl[i].cnt));
      chk($sformatf("tbl%0d_busy", i),  int'(bus.busy),  int'(|tbl[i].gnt));
      advance();
    end

    // Abort: requester 1 with length 10 drops req while count is 3.
    step(2'b10, 4'd0, 4'd10, "abort_idle");
    guard = 0;
    while (!(m_own == 1 && m_k == 3) && guard < 20) begin
      step(2'b10, 4'd0, 4'd10, "abort_run");
      guard++;
    end
    chk("abort_reach_count3", guard < 20 ? 1 : 0, 1);
    step(2'b00, 4'd0, 4'd10, "abort_drop");
    drive_sample(2'b00, 4'd0, 4'd10, 1'b1, "abort_after");
    chk("abort_after_gnt",   int'(bus.gnt),   0);
    chk("abort_after_count", int'(bus.count), 0);
    advance();

    // Abort in the expiry cycle: requester 0, length 2, req dropped at count 2.
    step(2'b01, 4'd2, 4'd0, "abt_tgt_idle");
    guard = 0;
    while (!(m_own == 0 && m_k == 2) && guard < 20) begin
      step(2'b01, 4'd2, 4'd0, "abt_tgt_run");
      guard++;
    end
    chk("abt_tgt_reach", guard < 20 ? 1 : 0, 1);
    drive_sample(2'b00, 4'd2, 4'd0, 1'b1, "abt_tgt_cycle");
    chk("abt_tgt_no_done", int'(bus.done), 0);
    advance();
    step(2'b00, 4'd2, 4'd0, "abt_tgt_after");

    // Asynchronous reset in the middle of a run at count 7.
    step(2'b01, 4'd12, 4'd0, "arst_idle");
    guard = 0;
    while (!(m_own == 0 && m_k == 7) && guard < 20) begin
      step(2'b01, 4'd12, 4'd0, "arst_run");
      guard++;
    end
    chk("arst_reach", guard < 20 ? 1 : 0, 1);
    #2;
    rstn = 1'b0;
    #1;
    chk("arst_gnt",   int'(bus.gnt),   0);
    chk("arst_done",  int'(bus.done),  0);
    chk("arst_count", int'(bus.count), 0);
    chk("arst_busy",  int'(bus.busy),  0);
    m_own  = -1;
    m_k    = 0;
    m_last = 1;
    bus.req = 2'b11;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    step(2'b11, 4'd1, 4'd1, "arst_rel_idle");
    drive_sample(2'b11, 4'd1, 4'd1, 1'b1, "arst_rel_grant");
    chk("arst_prio_r0", int'(bus.gnt), 1);
    advance();

    // Randomized traffic against the reference model.
    rq = 2'b11;
    for (int c = 0; c < 600; c++) begin
      for (int b = 0; b < 2; b++) begin
        if ($urandom_range(0, 5) == 0) rq[b] = ~rq[b];
      end
      step(rq, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
